// File: rtl/decode_pkg.sv
// decode_pkg: shared widths and types for the decode stage
package decode_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int IMM_W    = 19;
  localparam int BR_SHAMT = 2;
  localparam int NUM_REGS = 16;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/decode_regfile_unit_if.sv
// decode_regfile_unit_if: decode-stage operand, immediate and branch signals
interface decode_regfile_unit_if;
  import decode_pkg::*;
  reg_addr_t          ra, rb, rd, rd2;
  logic               branch, data_in_en, rwrite_sel, r2_sel;
  logic [IMM_W-1:0]   imm;
  word_t              data_in;
  logic               pc_select, cmp_result;
  word_t              branch_dir, imm_ext, data1, data2;
  modport master (
    output ra, rb, rd, rd2, branch, data_in_en, rwrite_sel, r2_sel, imm, data_in,
    input  pc_select, cmp_result, branch_dir, imm_ext, data1, data2
  );
  modport slave (
    input  ra, rb, rd, rd2, branch, data_in_en, rwrite_sel, r2_sel, imm, data_in,
    output pc_select, cmp_result, branch_dir, imm_ext, data1, data2
  );
endinterface

// File: rtl/decode_regfile.sv
// decode_regfile: 16x32 async-reset register array, one write port, two async read ports
// Optional write-through forwarding when DECODE_WRITE_BYPASS_EN is defined.
module decode_regfile
  import decode_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      we_i,
  input  reg_addr_t waddr_i,
  input  word_t     wdata_i,
  input  reg_addr_t raddr1_i,
  input  reg_addr_t raddr2_i,
  output word_t     rdata1_o,
  output word_t     rdata2_o
);
  word_t regs_q [NUM_REGS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) regs_q <= '{default: '0};
    else if (we_i) regs_q[waddr_i] <= wdata_i;
`ifdef DECODE_WRITE_BYPASS_EN
  logic fwd_en;
  assign fwd_en = we_i & rst_n;
  always_comb begin
    rdata1_o = (fwd_en && waddr_i == raddr1_i) ? wdata_i : regs_q[raddr1_i];
    rdata2_o = (fwd_en && waddr_i == raddr2_i) ? wdata_i : regs_q[raddr2_i];
  end
`else
  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];
`endif
endmodule

// File: rtl/decode_regfile_unit.sv
// decode_regfile_unit: decode stage with regfile, address muxes, sign-extend, branch shift, comparator
// Define DECODE_WRITE_BYPASS_EN to forward write data to same-cycle reads.
module decode_regfile_unit
  import decode_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  decode_regfile_unit_if.slave bus
);
  reg_addr_t waddr, raddr2;
  assign waddr  = bus.rwrite_sel ? bus.rd : bus.rb;
  assign raddr2 = bus.r2_sel ? bus.rd2 : bus.rb;
  decode_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (bus.data_in_en),
    .waddr_i  (waddr),
    .wdata_i  (bus.data_in),
    .raddr1_i (bus.ra),
    .raddr2_i (raddr2),
    .rdata1_o (bus.data1),
    .rdata2_o (bus.data2)
  );
  assign bus.imm_ext    = {{(DATA_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
  assign bus.branch_dir = bus.imm_ext << BR_SHAMT;
  assign bus.cmp_result = bus.data1 == bus.data2;
  assign bus.pc_select  = bus.cmp_result & bus.branch;
endmodule

// File: tb/tb_decode_regfile_unit.sv
// tb_decode_regfile_unit: directed table and sequence checks for decode_regfile_unit
module tb_decode_regfile_unit;
  logic clk = 0;
  logic rst_n = 1;
  int checks = 0;
  int errors = 0;
  decode_regfile_unit_if bus();
  decode_regfile_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  ra, rb, rd2;
    logic        r2_sel, branch;
    logic [18:0] imm;
    logic [31:0] d1, d2;
    logic        cmp, pc;
    logic [31:0] ext, dir;
  } vec_t;
  vec_t vecs [6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wr(input logic sel, input logic [3:0] addr, input logic [31:0] val);
    @(negedge clk);
    bus.rwrite_sel = sel;
    if (sel) bus.rd = addr; else bus.rb = addr;
    bus.data_in = val;
    bus.data_in_en = 1;
    @(posedge clk);
    #1 bus.data_in_en = 0;
  endtask
  initial begin
    vecs[0] = '{ra:0,  rb:15, rd2:0, r2_sel:0, branch:1, imm:19'h7FFFF, d1:32'h12345678, d2:32'h12345678, cmp:1, pc:1, ext:32'hFFFFFFFF, dir:32'hFFFFFFFC};
    vecs[1] = '{ra:15, rb:0,  rd2:3, r2_sel:1, branch:1, imm:19'h3FFFF, d1:32'h12345678, d2:32'hDEADBEEF, cmp:0, pc:0, ext:32'h0003FFFF, dir:32'h000FFFFC};
    vecs[2] = '{ra:4,  rb:0,  rd2:4, r2_sel:1, branch:0, imm:19'h40000, d1:32'hDEADBEEF, d2:32'hDEADBEEF, cmp:1, pc:0, ext:32'hFFFC0000, dir:32'hFFF00000};
    vecs[3] = '{ra:3,  rb:4,  rd2:0, r2_sel:0, branch:1, imm:19'h00000, d1:32'hDEADBEEF, d2:32'hDEADBEEF, cmp:1, pc:1, ext:32'h00000000, dir:32'h00000000};
    vecs[4] = '{ra:5,  rb:4,  rd2:3, r2_sel:1, branch:1, imm:19'h00001, d1:32'h00000000, d2:32'hDEADBEEF, cmp:0, pc:0, ext:32'h00000001, dir:32'h00000004};
    vecs[5] = '{ra:0,  rb:9,  rd2:0, r2_sel:1, branch:0, imm:19'h12345, d1:32'h12345678, d2:32'h12345678, cmp:1, pc:0, ext:32'h00012345, dir:32'h00048D14};
    bus.ra = 5; bus.rb = 9; bus.rd = 0; bus.rd2 = 0;
    bus.branch = 1; bus.data_in_en = 0; bus.rwrite_sel = 0; bus.r2_sel = 0;
    bus.imm = 0; bus.data_in = 0;
    #2 rst_n = 0;
    #1;
    chk("reset_data1", bus.data1, 0);
    chk("reset_data2", bus.data2, 0);
    chk("reset_cmp", {31'b0, bus.cmp_result}, 1);
    chk("reset_pc", {31'b0, bus.pc_select}, 1);
    @(negedge clk) rst_n = 1;
    wr(1, 3, 32'hDEADBEEF);
    bus.ra = 3; bus.r2_sel = 1; bus.rd2 = 4; #1;
    chk("wr_rd_data1", bus.data1, 32'hDEADBEEF);
    chk("wr_rd_data2", bus.data2, 0);
    chk("wr_rd_cmp", {31'b0, bus.cmp_result}, 0);
    chk("wr_rd_pc", {31'b0, bus.pc_select}, 0);
    wr(0, 4, 32'hDEADBEEF);
    bus.ra = 3; bus.r2_sel = 1; bus.rd2 = 4; bus.branch = 1; #1;
    chk("wr_rb_cmp", {31'b0, bus.cmp_result}, 1);
    chk("wr_rb_pc1", {31'b0, bus.pc_select}, 1);
    bus.branch = 0; #1;
    chk("wr_rb_pc0", {31'b0, bus.pc_select}, 0);
    wr(1, 0, 32'h12345678);
    wr(0, 15, 32'h12345678);
    foreach (vecs[i]) begin
      @(negedge clk);
      bus.ra = vecs[i].ra; bus.rb = vecs[i].rb; bus.rd2 = vecs[i].rd2;
      bus.r2_sel = vecs[i].r2_sel; bus.branch = vecs[i].branch; bus.imm = vecs[i].imm;
      #1;
      chk($sformatf("vec%0d_data1", i), bus.data1, vecs[i].d1);
      chk($sformatf("vec%0d_data2", i), bus.data2, vecs[i].d2);
      chk($sformatf("vec%0d_cmp", i), {31'b0, bus.cmp_result}, {31'b0, vecs[i].cmp});
      chk($sformatf("vec%0d_pc", i), {31'b0, bus.pc_select}, {31'b0, vecs[i].pc});
      chk($sformatf("vec%0d_ext", i), bus.imm_ext, vecs[i].ext);
      chk($sformatf("vec%0d_dir", i), bus.branch_dir, vecs[i].dir);
    end
    wr(1, 7, 32'h1);
    @(negedge clk);
    bus.rwrite_sel = 1; bus.rd = 7; bus.rb = 8; bus.data_in = 32'h2; bus.data_in_en = 1;
    bus.ra = 7; bus.r2_sel = 0; #1;
`ifdef DECODE_WRITE_BYPASS_EN
    chk("rdw_before_data1", bus.data1, 32'h2);
`else
    chk("rdw_before_data1", bus.data1, 32'h1);
`endif
    chk("rdw_rb_unaffected", bus.data2, 0);
    @(posedge clk);
    #1 bus.data_in_en = 0;
    chk("rdw_after_data1", bus.data1, 32'h2);
    chk("rdw_rb_not_written", bus.data2, 0);
    wr(0, 2, 32'h55);
    @(negedge clk);
    bus.ra = 2; #1;
    chk("arst_pre", bus.data1, 32'h55);
    rst_n = 0; #1;
    chk("arst_cleared", bus.data1, 0);
    bus.rwrite_sel = 0; bus.rb = 2; bus.data_in = 32'hAA; bus.data_in_en = 1;
    @(posedge clk); #1;
    chk("arst_no_write", bus.data1, 0);
    @(negedge clk) rst_n = 1;
    #1;
`ifdef DECODE_WRITE_BYPASS_EN
    chk("arst_release_fwd", bus.data1, 32'hAA);
`else
    chk("arst_release_old", bus.data1, 0);
`endif
    @(posedge clk); #1;
    chk("arst_first_write", bus.data1, 32'hAA);
    bus.data_in_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_regfile_unit.md
Name: decode_regfile_unit

Overview:
- Instruction-decode stage block with five parts: a 16x32 register file, two read ports and one write port, register-address select muxes, an immediate sign-extender, a branch-offset shifter, and an equality comparator.
- It produces the branch-taken select (pc_select) consumed by the fetch/PC logic.
- It feeds data1, data2 and imm_ext to the execute stage.

Parameters:
- DATA_W, 32, register and datapath width.
- ADDR_W, 4, register address width (2**ADDR_W registers).
- IMM_W, 19, raw immediate width.
- BR_SHAMT, 2, left-shift amount applied to the extended immediate to form branch_dir.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ra  in  ADDR_W  read-port-1 address.
- rb  in  ADDR_W  shared source/dest field.
- rd  in  ADDR_W  destination field.
- rd2  in  ADDR_W  alternate read-port-2 field.
- branch  in  1  instruction is a conditional branch.
- data_in_en  in  1  register write enable.
- rwrite_sel  in  1  write-address select: 0 = rb, 1 = rd.
- r2_sel  in  1  read-port-2 address select: 0 = rb, 1 = rd2.
- imm  in  IMM_W  raw immediate.
- data_in  in  DATA_W  write-back data.
- pc_select  out  1  branch taken.
- cmp_result  out  1  data1 == data2.
- branch_dir  out  DATA_W  imm_ext << BR_SHAMT.
- imm_ext  out  DATA_W  sign-extended imm.
- data1  out  DATA_W  read port 1.
- data2  out  DATA_W  read port 2.

Behaviour:
- Reset: while rst_n = 0, all 16 registers are cleared to 0 asynchronously. Writes are ignored during reset. Outputs are combinational and reflect the cleared array (data1 = data2 = 0, cmp_result = 1, pc_select = branch).
- Address muxes (combinational):
  - waddr = rwrite_sel ? rd : rb.
  - raddr2 = r2_sel ? rd2 : rb.
- Write: on a rising clk edge with rst_n = 1 and data_in_en = 1, reg[waddr] <= data_in.
  - All 16 registers are writable; register 0 is not hard-wired.
  - Single-cycle write latency.
- Read: asynchronous and combinational. data1 = reg[ra], data2 = reg[raddr2]. Reads have zero latency.
- Read during write to the same address (without WRITE_BYPASS_EN): the read returns the old value until the clock edge, then the new value.
- imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm}.
- branch_dir = imm_ext << BR_SHAMT. Zeros fill the low bits; the top bits are discarded (no saturation).
- cmp_result = (data1 == data2), full DATA_W bitwise equality, unsigned.
- pc_select = cmp_result & branch.
- Both read ports may address the same register; both then return the same value.
- Reset asserted mid-cycle clears the array immediately. The first write after release occurs on the first rising edge with rst_n = 1.
- There are no other state elements and no handshake.

Optional Feature:
- Macro: DECODE_WRITE_BYPASS_EN.
- Defined:
  - If data_in_en = 1 and waddr equals a read address, that read port returns data_in combinationally in the same cycle (write-through forwarding).
  - cmp_result and pc_select use the forwarded values.
  - Bypass is suppressed while rst_n = 0.
- Undefined: plain array read, with old-value semantics as in Behaviour.

Decomposition:
- Shared package decode_pkg holds:
  - constants DATA_W, ADDR_W, IMM_W, BR_SHAMT, NUM_REGS = 16.
  - typedefs word_t (logic [DATA_W-1:0]) and reg_addr_t (logic [ADDR_W-1:0]).
- One sub-module, decode_regfile:
  - async-reset register array, one write port, two async read ports, optional bypass.
- Sign-extend, shift, muxes and comparator stay inline in the top module.

Test Plan:
- Reset then read: pulse rst_n low, set ra = 5, r2_sel = 0, rb = 9 -> data1 = 0, data2 = 0, cmp_result = 1; branch = 1 -> pc_select = 1.
- Write/read via rd: rwrite_sel = 1, rd = 3, data_in = 32'hDEADBEEF, data_in_en = 1, one clk; then ra = 3, r2_sel = 1, rd2 = 4 -> data1 = 32'hDEADBEEF, data2 = 0, cmp_result = 0, pc_select = 0.
- Write via rb and compare: rwrite_sel = 0, rb = 4, data_in = 32'hDEADBEEF, one clk; ra = 3, r2_sel = 1, rd2 = 4, branch = 1 -> cmp_result = 1, pc_select = 1; branch = 0 -> pc_select = 0.
- Immediate sign and shift cases:
  - imm = 19'h7FFFF -> imm_ext = 32'hFFFFFFFF, branch_dir = 32'hFFFFFFFC.
  - imm = 19'h3FFFF -> imm_ext = 32'h0003FFFF, branch_dir = 32'h000FFFFC.
  - imm = 19'h40000 -> imm_ext = 32'hFFFC0000, branch_dir = 32'hFFF00000.
- Read during write: reg[7] = 1. Write 2 to addr 7 with ra = 7 before the edge -> data1 = 1 (bypass off) or 2 (DECODE_WRITE_BYPASS_EN); after the edge -> 2 in both builds.
- Async reset mid-operation: fill reg[2] = 32'h55, assert rst_n = 0 between clock edges -> data1 (ra = 2) reads 0 immediately. data_in_en = 1 during reset -> no write occurs.
